// File: rtl/nios_core_switch_debounce_pkg.sv
// Shared constants and helpers for the slide-switch conditioning path.
package nios_core_switch_debounce_pkg;

  localparam int unsigned SW_WIDTH                      = 16;
  localparam int unsigned DEBOUNCE_TICK_DIV_DEFAULT     = 50000;
  localparam int unsigned DEBOUNCE_STABLE_TICKS_DEFAULT = 10;

  // Ceiling log2; clog2(1) == 0, so callers size counters from values >= 2.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/nios_core_switch_debounce_if.sv
// Raw switch pins in, debounced levels and change strobes out.
interface nios_core_switch_debounce_if
  import nios_core_switch_debounce_pkg::*;
#(
  parameter int unsigned WIDTH = SW_WIDTH
);

  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_out;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             sw_change;

  modport master (
    input  sw_raw,
    output sw_out,
    output sw_rise,
    output sw_fall,
    output sw_change
  );

  modport slave (
    output sw_raw,
    input  sw_out,
    input  sw_rise,
    input  sw_fall,
    input  sw_change
  );

endinterface

// File: rtl/nios_core_switch_debounce_bit.sv
// One debounced switch bit: stability counter, accepted level and edge strobes.
module nios_core_switch_debounce_bit
  import nios_core_switch_debounce_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = DEBOUNCE_STABLE_TICKS_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_i,
  input  logic s2_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic strobe_d_o
);

  localparam int unsigned CW = clog2(STABLE_TICKS + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Any cycle back at the accepted level aborts a pending change.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (s2_i == level_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == CW'(STABLE_TICKS - 1)) begin
        cnt_d   = '0;
        level_d = s2_i;
        rise_d  = s2_i;
        fall_d  = ~s2_i;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o    = level_q;
  assign rise_o     = rise_q;
  assign fall_o     = fall_q;
  assign strobe_d_o = rise_d | fall_d;

endmodule

// File: rtl/nios_core_switch_debounce.sv
// Two-flop synchroniser, shared debounce prescaler and per-bit debouncers
// feeding the switch PIO in_port.
module nios_core_switch_debounce
  import nios_core_switch_debounce_pkg::*;
#(
  parameter int unsigned WIDTH        = SW_WIDTH,
  parameter int unsigned TICK_DIV     = DEBOUNCE_TICK_DIV_DEFAULT,
  parameter int unsigned STABLE_TICKS = DEBOUNCE_STABLE_TICKS_DEFAULT
) (
  input logic                         clk,
  input logic                         reset,
  nios_core_switch_debounce_if.master sw
);

  localparam int unsigned TCW = clog2(TICK_DIV);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [TCW-1:0]   tick_cnt_q, tick_cnt_d;
  logic             tick;
  logic             change_q, change_d;
  logic [WIDTH-1:0] level, rise, fall, strobe_d;

  // Change strobe is built from next-cycle rise/fall so it lands with them.
  always_comb begin
    tick       = (tick_cnt_q == TCW'(TICK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + TCW'(1);
    change_d   = |strobe_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q       <= '0;
      s2_q       <= '0;
      tick_cnt_q <= '0;
      change_q   <= 1'b0;
    end else begin
      s1_q       <= sw.sw_raw;
      s2_q       <= s1_q;
      tick_cnt_q <= tick_cnt_d;
      change_q   <= change_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    nios_core_switch_debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_bit (
      .clk       (clk),
      .reset     (reset),
      .tick_i    (tick),
      .s2_i      (s2_q[i]),
      .level_o   (level[i]),
      .rise_o    (rise[i]),
      .fall_o    (fall[i]),
      .strobe_d_o(strobe_d[i])
    );
  end

  assign sw.sw_out    = level;
  assign sw.sw_rise   = rise;
  assign sw.sw_fall   = fall;
  assign sw.sw_change = change_q;

endmodule

// File: tb/tb_nios_core_switch_debounce.sv
// Directed bench for the switch debouncer with a short prescaler (4) and 3 stable ticks.
module tb_nios_core_switch_debounce;

  localparam int unsigned W  = 16;
  localparam int unsigned TD = 4;
  localparam int unsigned ST = 3;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  nios_core_switch_debounce_if #(.WIDTH(W)) sw_if ();

  nios_core_switch_debounce #(
    .WIDTH       (W),
    .TICK_DIV    (TD),
    .STABLE_TICKS(ST)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .sw   (sw_if)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] raw);
    reset = 1'b1;
    sw_if.sw_raw = raw;
    step();
    reset = 1'b0;
  endtask

  // Steps ncyc cycles, noting the first cycle where sw_out[b]==target and the strobes then.
  task automatic watch(input int ncyc, input int b, input logic target,
                       output int first, output int nstrobe, output int nchange,
                       output logic [15:0] rise_at, output logic [15:0] fall_at,
                       output logic change_at);
    first = -1; nstrobe = 0; nchange = 0;
    rise_at = '0; fall_at = '0; change_at = 1'b0;
    for (int i = 1; i <= ncyc; i++) begin
      step();
      if ((sw_if.sw_rise | sw_if.sw_fall) != '0) nstrobe++;
      if (sw_if.sw_change) nchange++;
      if (first < 0 && sw_if.sw_out[b] === target) begin
        first     = i;
        rise_at   = sw_if.sw_rise;
        fall_at   = sw_if.sw_fall;
        change_at = sw_if.sw_change;
      end
    end
  endtask

  task automatic test_reset();
    int first;
    logic [48:0] obs;
    sw_if.sw_raw = 16'hFFFF;
    reset = 1'b1;
    step();
    step();
    obs = {sw_if.sw_out, sw_if.sw_rise, sw_if.sw_fall, sw_if.sw_change};
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL reset_hold: got %h expected 0", obs);
    end
    reset = 1'b0;
    step();
    obs = {sw_if.sw_out, sw_if.sw_rise, sw_if.sw_fall, sw_if.sw_change};
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL reset_exit: got %h expected 0", obs);
    end
    first = -1;
    for (int k = 2; k <= 20; k++) begin
      step();
      if (sw_if.sw_out !== 16'h0000) begin
        first = k;
        break;
      end
    end
    vectors++;
    if (first !== 12) begin
      miscompares++;
      $display("FAIL reset_accept_cycle: got %0d expected 12", first);
    end
    obs = {sw_if.sw_out, sw_if.sw_rise, sw_if.sw_fall, sw_if.sw_change};
    vectors++;
    if (obs !== {16'hFFFF, 16'hFFFF, 16'h0000, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_accept_strobe: got %h expected %h", obs,
               {16'hFFFF, 16'hFFFF, 16'h0000, 1'b1});
    end
    step();
    obs = {sw_if.sw_out, sw_if.sw_rise, sw_if.sw_fall, sw_if.sw_change};
    vectors++;
    if (obs !== {16'hFFFF, 16'h0000, 16'h0000, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_strobe_one_cycle: got %h expected %h", obs,
               {16'hFFFF, 16'h0000, 16'h0000, 1'b0});
    end
  endtask

  task automatic test_clean_step();
    int first, ns, nc;
    logic [15:0] r, f;
    logic c;
    do_reset(16'h0000);
    repeat (4) step();
    vectors++;
    if (sw_if.sw_out !== 16'h0000) begin
      miscompares++;
      $display("FAIL step_idle: got %h expected 0000", sw_if.sw_out);
    end
    sw_if.sw_raw = 16'h0008;
    watch(25, 3, 1'b1, first, ns, nc, r, f, c);
    vectors++;
    if (first < 11 || first > 14) begin
      miscompares++;
      $display("FAIL step_latency: got %0d expected 11..14", first);
    end
    vectors++;
    if ({r, f, c} !== {16'h0008, 16'h0000, 1'b1}) begin
      miscompares++;
      $display("FAIL step_strobe: got %h/%h/%b expected 0008/0000/1", r, f, c);
    end
    vectors++;
    if (ns !== 1 || nc !== 1) begin
      miscompares++;
      $display("FAIL step_pulse_count: got %0d/%0d expected 1/1", ns, nc);
    end
    vectors++;
    if (sw_if.sw_out !== 16'h0008) begin
      miscompares++;
      $display("FAIL step_level: got %h expected 0008", sw_if.sw_out);
    end
  endtask

  task automatic test_bounce();
    int nb, first, ns, nc;
    logic [15:0] r, f;
    logic c;
    nb = 0;
    for (int seg = 0; seg < 4; seg++) begin
      sw_if.sw_raw[0] = (seg % 2 == 0);
      repeat (3) begin
        step();
        if ((sw_if.sw_rise | sw_if.sw_fall) != '0 || sw_if.sw_change) nb++;
      end
    end
    vectors++;
    if (nb !== 0 || sw_if.sw_out !== 16'h0008) begin
      miscompares++;
      $display("FAIL bounce_quiet: got %0d strobes, out %h expected 0 strobes, out 0008",
               nb, sw_if.sw_out);
    end
    sw_if.sw_raw[0] = 1'b1;
    watch(25, 0, 1'b1, first, ns, nc, r, f, c);
    vectors++;
    if (first < 11 || first > 14) begin
      miscompares++;
      $display("FAIL bounce_latency: got %0d expected 11..14", first);
    end
    vectors++;
    if (r !== 16'h0001 || ns !== 1) begin
      miscompares++;
      $display("FAIL bounce_rise: got %h x%0d expected 0001 x1", r, ns);
    end
  endtask

  task automatic test_abort();
    int nb, first, ns, nc;
    logic [15:0] r, f;
    logic c;
    nb = 0;
    sw_if.sw_raw[5] = 1'b1;
    repeat (8) begin
      step();
      if ((sw_if.sw_rise | sw_if.sw_fall) != '0 || sw_if.sw_change) nb++;
    end
    sw_if.sw_raw[5] = 1'b0;
    watch(20, 5, 1'b1, first, ns, nc, r, f, c);
    vectors++;
    if (first !== -1 || nb + ns + nc !== 0 || sw_if.sw_out !== 16'h0009) begin
      miscompares++;
      $display("FAIL abort_quiet: got first=%0d strobes=%0d out=%h expected -1/0/0009",
               first, nb + ns + nc, sw_if.sw_out);
    end
    sw_if.sw_raw[5] = 1'b1;
    watch(25, 5, 1'b1, first, ns, nc, r, f, c);
    vectors++;
    if (first < 11 || first > 14) begin
      miscompares++;
      $display("FAIL abort_count_cleared: got %0d expected 11..14", first);
    end
    vectors++;
    if (r !== 16'h0020 || f !== 16'h0000) begin
      miscompares++;
      $display("FAIL abort_rise: got %h/%h expected 0020/0000", r, f);
    end
  endtask

  task automatic test_simultaneous();
    int first, ns, nc;
    logic [15:0] r, f;
    logic c;
    sw_if.sw_raw = 16'h00F0;
    repeat (20) step();
    vectors++;
    if (sw_if.sw_out !== 16'h00F0) begin
      miscompares++;
      $display("FAIL simul_setup: got %h expected 00F0", sw_if.sw_out);
    end
    sw_if.sw_raw = 16'h0F00;
    watch(25, 8, 1'b1, first, ns, nc, r, f, c);
    vectors++;
    if ({r, f, c} !== {16'h0F00, 16'h00F0, 1'b1}) begin
      miscompares++;
      $display("FAIL simul_strobes: got %h/%h/%b expected 0F00/00F0/1", r, f, c);
    end
    vectors++;
    if (nc !== 1 || ns !== 1) begin
      miscompares++;
      $display("FAIL simul_single_pulse: got %0d/%0d expected 1/1", nc, ns);
    end
    vectors++;
    if (sw_if.sw_out !== 16'h0F00 || first < 11 || first > 14) begin
      miscompares++;
      $display("FAIL simul_level: got %h at %0d expected 0F00 at 11..14", sw_if.sw_out, first);
    end
  endtask

  task automatic test_reset_mid_count();
    int first, ns, nc;
    logic [15:0] r, f;
    logic c;
    logic hit;
    logic [48:0] obs;
    hit = 1'b0;
    sw_if.sw_raw = 16'h0F80;
    for (int i = 0; i < 20; i++) begin
      step();
      if (dut.g_bit[7].u_bit.cnt_q == 2) begin
        hit = 1'b1;
        break;
      end
    end
    vectors++;
    if (hit !== 1'b1 || sw_if.sw_out[7] !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_reach_cnt2: got hit=%b out7=%b expected 1/0", hit, sw_if.sw_out[7]);
    end
    reset = 1'b1;
    step();
    obs = {sw_if.sw_out, sw_if.sw_rise, sw_if.sw_fall, sw_if.sw_change};
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL midreset_clear: got %h expected 0", obs);
    end
    reset = 1'b0;
    watch(25, 7, 1'b1, first, ns, nc, r, f, c);
    vectors++;
    if (first !== 12) begin
      miscompares++;
      $display("FAIL midreset_full_wait: got %0d expected 12", first);
    end
    vectors++;
    if (r !== 16'h0F80 || ns !== 1 || nc !== 1) begin
      miscompares++;
      $display("FAIL midreset_rise: got %h x%0d/%0d expected 0F80 x1/1", r, ns, nc);
    end
  endtask

  initial begin
    reset = 1'b1;
    sw_if.sw_raw = '0;
    test_reset();
    test_clean_step();
    test_bounce();
    test_abort();
    test_simultaneous();
    test_reset_mid_count();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
